// File: rtl/program_loader.sv
// Boot-time instruction loader: packs UART bytes big-endian into words, writes them to
// consecutive word addresses and releases the CPU once the halt word has been stored.
module program_loader #(
    parameter int unsigned       NBITS     = 32,
    parameter int unsigned       CELDAS    = 60,
    parameter logic [NBITS-1:0]  HALT_WORD = {NBITS{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_PC,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_wdata,
    output logic             o_mem_we,
    output logic             o_cpu_enable,
    output logic             o_loading,
    output logic             o_done,
    output logic             o_error
);

    localparam logic [NBITS-1:0] LastAddr = NBITS'(CELDAS - 4);
    localparam logic [NBITS-1:0] WordStep = NBITS'(4);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [NBITS-1:0] word_q, word_d;

    logic [NBITS-1:0] addr_next;
    logic [NBITS-1:0] word_shifted;

    assign addr_next    = wr_addr_q + WordStep;
    assign word_shifted = {word_q[NBITS-9:0], i_rx_data};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_addr_q  <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StLoad;
            end
            StLoad: begin
                if (i_rx_valid && (byte_cnt_q == 2'd3)) state_d = StWrite;
            end
            StWrite: begin
                if (word_q == HALT_WORD) begin
                    state_d = StDone;
                end else if (addr_next > LastAddr) begin
                    state_d = StError;
                end else begin
                    state_d = StLoad;
                end
            end
            StDone, StError: begin
                if (i_start) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        wr_addr_d  = wr_addr_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (i_start) begin
                    wr_addr_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            StLoad: begin
                if (i_rx_valid) begin
                    word_d     = word_shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            StWrite: begin
                // A byte landing in the write cycle starts the next word; word_q is only
                // overwritten at the edge, so the current write still sees the full word.
                if (i_rx_valid) begin
                    word_d     = word_shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                if ((word_q != HALT_WORD) && (addr_next <= LastAddr)) begin
                    wr_addr_d = addr_next;
                end
            end
            default: begin
                wr_addr_d  = '0;
                byte_cnt_d = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_mem_we     = 1'b0;
        o_cpu_enable = 1'b0;
        o_loading    = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        o_mem_addr   = i_PC;
        o_mem_wdata  = word_q;
        unique case (state_q)
            StLoad: o_loading = 1'b1;
            StWrite: begin
                o_loading  = 1'b1;
                o_mem_we   = 1'b1;
                o_mem_addr = wr_addr_q;
            end
            StDone: begin
                o_done       = 1'b1;
                o_cpu_enable = 1'b1;
            end
            StError: o_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: byte streams from word lists, checked against a
// word-level model of where each word must land and how the load ends.
module tb_program_loader;

    localparam int unsigned NBITS  = 32;
    localparam int unsigned CELDAS = 60;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              i_start;
    logic [NBITS-1:0]  i_PC;
    logic [NBITS-1:0]  o_mem_addr;
    logic [NBITS-1:0]  o_mem_wdata;
    logic              o_mem_we;
    logic              o_cpu_enable;
    logic              o_loading;
    logic              o_done;
    logic              o_error;

    always #5 clk = ~clk;

    program_loader #(
        .NBITS    (NBITS),
        .CELDAS   (CELDAS),
        .HALT_WORD(HALT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_start     (i_start),
        .i_PC        (i_PC),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .o_cpu_enable(o_cpu_enable),
        .o_loading   (o_loading),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] prog[$];

    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            log_addr.push_back(o_mem_addr);
            log_data.push_back(o_mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        step();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check_eq({tag, "_we"}, o_mem_we, 1'b0);
        check_eq({tag, "_wdata"}, o_mem_wdata, 32'h0);
        check_eq({tag, "_cpu_en"}, o_cpu_enable, 1'b0);
        check_eq({tag, "_loading"}, o_loading, 1'b0);
        check_eq({tag, "_done"}, o_done, 1'b0);
        check_eq({tag, "_error"}, o_error, 1'b0);
        check_eq({tag, "_addr"}, o_mem_addr, i_PC);
    endtask

    // Word-level model: word k goes to address 4k; the load ends on the halt word or
    // when the word just written occupied the last cell of memory.
    task automatic run_program(input string tag, input int max_gap);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        bit          halted = 1'b0;
        bit          overflow = 1'b0;
        int          base = log_addr.size();
        logic [31:0] w;

        for (int i = 0; i < prog.size(); i++) begin
            exp_a.push_back(32'(4 * i));
            exp_d.push_back(prog[i]);
            if (prog[i] == HALT) begin
                halted = 1'b1;
                break;
            end
            if (4 * i + 4 > int'(CELDAS) - 4) begin
                overflow = 1'b1;
                break;
            end
        end

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_start_loading"}, o_loading, 1'b1);
        check_eq({tag, "_start_cpu_off"}, o_cpu_enable, 1'b0);

        for (int k = 0; k < exp_d.size(); k++) begin
            w = exp_d[k];
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(max_gap, 0)) step();
                send_byte(8'(w >> (24 - 8 * b)));
            end
        end

        if (exp_d.size() > 0) begin
            @(negedge clk);
            check_eq({tag, "_last_we"}, o_mem_we, 1'b1);
            check_eq({tag, "_last_addr"}, o_mem_addr, exp_a[exp_a.size() - 1]);
            check_eq({tag, "_last_data"}, o_mem_wdata, exp_d[exp_d.size() - 1]);
            step();
            @(negedge clk);
            check_eq({tag, "_done"}, o_done, halted);
            check_eq({tag, "_error"}, o_error, overflow);
            check_eq({tag, "_cpu_en"}, o_cpu_enable, halted);
            check_eq({tag, "_loading"}, o_loading, !(halted || overflow));
            check_eq({tag, "_we_off"}, o_mem_we, 1'b0);
            check_eq({tag, "_pc_addr"}, o_mem_addr, i_PC);
        end

        check_eq({tag, "_nwrites"}, 64'(log_addr.size() - base), 64'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && base + k < log_addr.size(); k++) begin
            check_eq($sformatf("%s_waddr%0d", tag, k), log_addr[base + k], exp_a[k]);
            check_eq($sformatf("%s_wdata%0d", tag, k), log_data[base + k], exp_d[k]);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int len;

        i_reset    = 1'b1;
        i_rx_data  = 8'h0;
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
        i_PC       = $urandom;
        step();
        step();
        i_reset = 1'b0;
        check_idle_outputs("reset");

        // Bytes in IDLE are ignored
        base = log_addr.size();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        @(negedge clk);
        check_eq("idle_bytes_loading", o_loading, 1'b0);
        check_eq("idle_bytes_nwrites", 64'(log_addr.size() - base), 64'd0);

        // Basic two-word program
        i_PC = 32'd8;
        prog = '{32'h0022_2020, HALT};
        run_program("basic", 2);
        check_eq("basic_pc8", o_mem_addr, 32'd8);

        // Bytes in DONE without a start are ignored
        base = log_addr.size();
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        @(negedge clk);
        check_eq("done_bytes_done", o_done, 1'b1);
        check_eq("done_bytes_nwrites", 64'(log_addr.size() - base), 64'd0);

        // Reload from DONE with a halt-only program
        prog = '{HALT};
        run_program("reload", 1);

        // Back-to-back bytes, three words
        prog = '{rand_word(), rand_word(), HALT};
        run_program("b2b", 0);

        // Overflow: 15 non-halt words fill memory
        prog.delete();
        for (int i = 0; i < 15; i++) prog.push_back(rand_word());
        run_program("ovf", 1);
        prog = '{rand_word(), HALT};
        run_program("retry", 0);

        // Reset mid-way through the second word
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        base = log_addr.size();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check_idle_outputs("midreset");
        check_eq("midreset_nwrites", 64'(log_addr.size() - base), 64'd1);
        prog = '{32'hA1B2_C3D4, HALT};
        run_program("after_reset", 0);

        // Random programs
        for (int r = 0; r < 8; r++) begin
            i_PC = $urandom;
            len  = int'($urandom_range(17, 1));
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_word());
            if ($urandom_range(3, 0) != 0) prog[len - 1] = HALT;
            run_program($sformatf("rnd%0d", r), int'($urandom_range(2, 0)));
            if (o_loading) begin
                i_reset = 1'b1;
                step();
                i_reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
